// File: rtl/mwc_pkg.sv
// Shared types for the memory-write checker: FSM states, failure codes and
// the table index width helper.
package mwc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        PASS,
        FAIL
    } mwc_state_t;

    typedef enum logic [1:0] {
        FAIL_NONE,
        FAIL_MISMATCH,
        FAIL_TIMEOUT
    } mwc_fail_t;

    // A one-entry table still needs a 1-bit index port.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mwc_exp_table.sv
// Expected-write table: DEPTH entries of {address, data}, synchronous write,
// combinational read. Contents have no reset and survive a checker reset.
module mwc_exp_table #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [ADDR_W+DATA_W-1:0] entry_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            entry_q[wr_idx] <= {wr_addr, wr_data};
        end
    end

    assign {rd_addr, rd_data} = entry_q[rd_idx];

endmodule

// File: rtl/mem_write_checker.sv
// Watches the data-memory store port and checks stores, in order, against
// the expected-write table; reports pass/fail with mismatch capture.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         load_en,
    input  logic [idx_w(DEPTH)-1:0]      load_idx,
    input  logic [ADDR_W-1:0]            load_addr,
    input  logic [DATA_W-1:0]            load_data,
    input  logic [$clog2(DEPTH+1)-1:0]   exp_count,
    input  logic                         ign_en,
    input  logic [ADDR_W-1:0]            ign_addr,
    input  logic [TIMEOUT_W-1:0]         timeout_cycles,
    input  logic                         mem_write,
    input  logic [ADDR_W-1:0]            data_adr,
    input  logic [DATA_W-1:0]            write_data,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [1:0]                   fail_code,
    output logic [$clog2(DEPTH+1)-1:0]   match_count,
    output logic [ADDR_W-1:0]            fail_addr,
    output logic [DATA_W-1:0]            fail_data
);

    localparam int IDX_W = idx_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    mwc_state_t        state_q, state_d;
    mwc_fail_t         fail_code_q, fail_code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  match_count_q, match_count_d;
    logic [TIMEOUT_W-1:0] tc_q, tc_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [CNT_W-1:0]  match_inc;
    logic              hit;
    logic              ignored;

    mwc_exp_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk     (clk),
        .we      (load_en && (state_q == IDLE)),
        .wr_idx  (load_idx),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_idx  (match_count_q[IDX_W-1:0]),
        .rd_addr (exp_addr),
        .rd_data (exp_data)
    );

    // match_count doubles as the table pointer: entries are consumed in order.
    assign match_inc = match_count_q + CNT_W'(1);
    assign hit       = mem_write && (data_adr == exp_addr) && (write_data == exp_data);
    assign ignored   = ign_en && (data_adr == ign_addr);

    always_comb begin
        state_d       = state_q;
        fail_code_d   = fail_code_q;
        cnt_d         = cnt_q;
        match_count_d = match_count_q;
        tc_d          = tc_q;
        timer_d       = timer_q;
        fail_addr_d   = fail_addr_q;
        fail_data_d   = fail_data_q;

        if (state_q == ARMED) begin
            if (hit) begin
                match_count_d = match_inc;
                timer_d       = '0;
                if (match_inc == cnt_q) begin
                    state_d = PASS;
                end
            end else if (mem_write && !ignored) begin
                state_d     = FAIL;
                fail_code_d = FAIL_MISMATCH;
                fail_addr_d = data_adr;
                fail_data_d = write_data;
            end else if (tc_q != '0) begin
                // Expiry is judged on the pre-increment value so FAIL lands
                // exactly timeout_cycles edges after the last progress.
                if (timer_q == tc_q - 1'b1) begin
                    state_d     = FAIL;
                    fail_code_d = FAIL_TIMEOUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        end else if (start) begin
            cnt_d         = exp_count;
            tc_d          = timeout_cycles;
            match_count_d = '0;
            timer_d       = '0;
            fail_code_d   = FAIL_NONE;
            fail_addr_d   = '0;
            fail_data_d   = '0;
            state_d       = (exp_count == '0) ? PASS : ARMED;
        end

        busy_d = (state_d == ARMED);
        done_d = (state_d == PASS) || (state_d == FAIL);
        pass_d = (state_d == PASS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fail_code_q   <= FAIL_NONE;
            cnt_q         <= '0;
            match_count_q <= '0;
            tc_q          <= '0;
            timer_q       <= '0;
            fail_addr_q   <= '0;
            fail_data_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fail_code_q   <= fail_code_d;
            cnt_q         <= cnt_d;
            match_count_q <= match_count_d;
            tc_q          <= tc_d;
            timer_q       <= timer_d;
            fail_addr_q   <= fail_addr_d;
            fail_data_q   <= fail_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_code_q;
    assign match_count = match_count_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;

endmodule
